branch_unit: RTL

- Branch-resolution and fetch-PC stage. Sits directly downstream of the branch comparator.
- Drives the comparator's unsigned-select from funct3. Consumes its less/equal results for the EX-stage instruction and decides taken/not-taken for conditional branches, JAL and JALR.
- Owns the fetch PC register, predicting not-taken (PC+4). Issues a registered redirect with a pipeline flush. Keeps saturating branch statistics counters.

---
 rtl/branch_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/branch_unit.sv
// Branch resolution and fetch-PC stage with a not-taken predictor,
// a registered redirect/flush, and saturating branch statistics.
module branch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic             insn_vld_i,
    input  logic             is_branch_i,
    input  logic             is_jal_i,
    input  logic             is_jalr_i,
    input  logic [2:0]       funct3_i,
    input  logic             br_less_i,
    input  logic             br_equal_i,
    input  logic [31:0]      pc_ex_i,
    input  logic [31:0]      imm_i,
    input  logic [31:0]      rs1_data_i,
    input  logic             clr_cnt_i,
    output logic             br_unsigned_o,
    output logic [31:0]      pc_o,
    output logic             flush_o,
    output logic             illegal_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    typedef enum logic {RUN, REDIR} state_t;

    state_t             state_q;
    logic [31:0]        pc_q;
    logic [31:0]        tgt_q;
    logic               ill_q;
    logic               mis_q;
    logic [CNT_W-1:0]   br_q;
    logic [CNT_W-1:0]   tk_q;

    logic               cond;
    logic               is_br;
    logic               taken;
    logic               resolve;
    logic               ill_f3;
    logic [31:0]        target;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        cond   = 1'b0;
        ill_f3 = 1'b0;
        unique case (funct3_i)
            3'b000: cond = br_equal_i;
            3'b001: cond = !br_equal_i;
            3'b100: cond = br_less_i;
            3'b101: cond = !br_less_i;
            3'b110: cond = br_less_i;
            3'b111: cond = !br_less_i;
            3'b010: ill_f3 = 1'b1;
            3'b011: ill_f3 = 1'b1;
        endcase
    end

    // jalr > jal > branch when several type flags are set
    always_comb begin
        is_br  = is_branch_i && !is_jal_i && !is_jalr_i;
        taken  = is_jalr_i || is_jal_i || (is_br && cond);
        if (is_jalr_i)
            target = (rs1_data_i + imm_i) & ~32'h1;
        else
            target = pc_ex_i + imm_i;
    end

    assign resolve = insn_vld_i && !stall_i && (state_q == RUN);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            tgt_q   <= 32'h0;
            ill_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            ill_q <= resolve && is_br && ill_f3;
            mis_q <= resolve && taken && target[1];
            unique case (state_q)
                RUN: begin
                    if (!stall_i)
                        pc_q <= pc_q + 32'd4;
                    if (resolve && taken) begin
                        tgt_q   <= target;
                        state_q <= REDIR;
                    end
                end
                REDIR: begin
                    if (!stall_i) begin
                        pc_q    <= tgt_q;
                        state_q <= RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            br_q <= '0;
            tk_q <= '0;
        end else if (clr_cnt_i) begin
            br_q <= '0;
            tk_q <= '0;
        end else if (resolve && is_br) begin
            if (br_q != '1)
                br_q <= br_q + ONE;
            if (cond && tk_q != '1)
                tk_q <= tk_q + ONE;
        end
    end

    assign br_unsigned_o = funct3_i[1];
    assign pc_o          = pc_q;
    assign flush_o       = (state_q == REDIR);
    assign illegal_o     = ill_q;
    assign misalign_o    = mis_q;
    assign br_cnt_o      = br_q;
    assign taken_cnt_o   = tk_q;

endmodule
